// File: rtl/iscas_resp_misr.sv
// MISR response compactor for an ISCAS89 netlist under test: discards a warm-up
// window, folds RUN_CYCLES responses into a Galois MISR, then compares to a golden signature.
module iscas_resp_misr #(
  parameter int                   IN_WIDTH   = 6,
  parameter int                   SIG_WIDTH  = 16,
  parameter logic [SIG_WIDTH-1:0] POLY       = 16'h1021,
  parameter logic [SIG_WIDTH-1:0] SEED       = 16'h0000,
  parameter int                   WARMUP     = 8,
  parameter int                   RUN_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IN_WIDTH-1:0]  resp,
  input  logic [SIG_WIDTH-1:0] expected,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_WIDTH-1:0] signature
);

  localparam int MAXC = (WARMUP > RUN_CYCLES) ? WARMUP : RUN_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] WARM_LAST = CW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CW-1:0] RUN_LAST  = CW'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_COMPACT, S_DONE} state_t;

  // A zero-length warm-up skips straight into compaction.
  localparam state_t FIRST = (WARMUP > 0) ? S_WARM : S_COMPACT;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [SIG_WIDTH-1:0] exp_q, exp_n, sig_n, misr_next;
  logic                 pass_n;

  assign misr_next = {signature[SIG_WIDTH-2:0], 1'b0}
                   ^ (signature[SIG_WIDTH-1] ? POLY : '0)
                   ^ SIG_WIDTH'(resp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      signature <= SEED;
      exp_q     <= '0;
      pass      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      signature <= sig_n;
      exp_q     <= exp_n;
      pass      <= pass_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sig_n   = signature;
    exp_n   = exp_q;
    pass_n  = pass;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          sig_n   = SEED;
          exp_n   = expected;
          cnt_n   = '0;
          pass_n  = 1'b0;
          state_n = FIRST;
        end
      end
      S_WARM: begin
        if (cnt == WARM_LAST) begin
          cnt_n   = '0;
          state_n = S_COMPACT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_COMPACT: begin
        sig_n = misr_next;
        if (cnt == RUN_LAST) begin
          cnt_n   = '0;
          pass_n  = (misr_next == exp_q);
          state_n = S_DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state == S_WARM) || (state == S_COMPACT);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_iscas_resp_misr.sv
// Bench for iscas_resp_misr: five parameterisations share stimulus; each scenario
// checks one instance against a queue-driven MISR reference model.
module tb_iscas_resp_misr;
  localparam int N = 5;
  localparam logic [15:0] POLY = 16'h1021;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [5:0]  resp = '0;
  logic [15:0] expected = '0;
  logic [N-1:0] busy, done, pass;
  logic [15:0] sig [N];

  int n_tests = 0, n_fail = 0;
  logic fixed_noise = 1'b0;
  logic [5:0]  stim_q[$];
  logic [15:0] sig_hist[$];

  int          w_of    [N] = '{0, 0, 0, 3, 8};
  int          r_of    [N] = '{4, 2, 1, 1, 1024};
  logic [15:0] seed_of [N] = '{16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000};

  always #5 clk = ~clk;

  iscas_resp_misr #(.WARMUP(0), .RUN_CYCLES(4)) u0 (.clk(clk), .rst(rst), .start(start),
    .resp(resp), .expected(expected), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .signature(sig[0]));
  iscas_resp_misr #(.WARMUP(0), .RUN_CYCLES(2)) u1 (.clk(clk), .rst(rst), .start(start),
    .resp(resp), .expected(expected), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .signature(sig[1]));
  iscas_resp_misr #(.WARMUP(0), .RUN_CYCLES(1), .SEED(16'h8000)) u2 (.clk(clk), .rst(rst), .start(start),
    .resp(resp), .expected(expected), .busy(busy[2]), .done(done[2]), .pass(pass[2]), .signature(sig[2]));
  iscas_resp_misr #(.WARMUP(3), .RUN_CYCLES(1)) u3 (.clk(clk), .rst(rst), .start(start),
    .resp(resp), .expected(expected), .busy(busy[3]), .done(done[3]), .pass(pass[3]), .signature(sig[3]));
  iscas_resp_misr u4 (.clk(clk), .rst(rst), .start(start),
    .resp(resp), .expected(expected), .busy(busy[4]), .done(done[4]), .pass(pass[4]), .signature(sig[4]));

  // Reference: shift left, fold the dropped MSB back through POLY, XOR in the response.
  function automatic logic [15:0] model(input logic [15:0] seed);
    logic [15:0] s = seed;
    foreach (stim_q[i]) begin
      logic fb = s[15];
      s = s << 1;
      if (fb) s = s ^ POLY;
      s = s ^ 16'(stim_q[i]);
    end
    return s;
  endfunction

  function automatic logic [5:0] noise();
    return fixed_noise ? 6'h3F : 6'($urandom);
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Launches one run on instance idx; stim_q feeds the compaction edges, everything
  // else (including expected after the accept edge) is noise the DUT must ignore.
  task automatic do_run(input int idx, input logic [15:0] e, input int poke_at,
                        output int lat, output int bcnt);
    int w = w_of[idx];
    int r = r_of[idx];
    int k = 0;
    sig_hist.delete();
    lat = 0; bcnt = 0;
    expected = e; start = 1'b1; resp = noise();
    for (int ed = 1; ed <= w + r + 20; ed++) begin
      @(posedge clk); #1;
      sig_hist.push_back(sig[idx]);
      if (busy[idx]) bcnt++;
      if (done[idx]) begin lat = ed; break; end
      start = (ed == poke_at);
      expected = 16'($urandom);
      if (ed >= w + 1 && k < stim_q.size()) begin resp = stim_q[k]; k++; end
      else resp = noise();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if ({busy[i], done[i], pass[i], sig[i]} !== {3'b000, seed_of[i]}) begin
        n_fail++;
        $display("FAIL reset_init[%0d]: got b%0b d%0b p%0b sig %h, want 000 sig %h",
                 i, busy[i], done[i], pass[i], sig[i], seed_of[i]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b1; expected = 16'($urandom);
    for (int ed = 1; ed <= 20; ed++) begin
      resp = 6'($urandom) | 6'h01;
      @(posedge clk); #1;
      start = 1'b0;
    end
    n_tests++;
    if (busy[4] !== 1'b1) begin
      n_fail++; $display("FAIL reset_prerun_busy: got %b want 1", busy[4]);
    end
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if ({busy[4], done[4], pass[4], sig[4]} !== {3'b000, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_midrun: got b%0b d%0b p%0b sig %h, want 000 sig 0000",
               busy[4], done[4], pass[4], sig[4]);
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if ({busy[4], done[4], sig[4]} !== {2'b00, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_idle_hold: got b%0b d%0b sig %h, want 00 sig 0000", busy[4], done[4], sig[4]);
    end
  endtask

  task automatic test_zero_response();
    int lat, bc;
    do_reset();
    stim_q = '{6'h00, 6'h00, 6'h00, 6'h00};
    do_run(0, 16'h0000, 0, lat, bc);
    n_tests++;
    if (lat !== 5) begin n_fail++; $display("FAIL zero_latency: got %0d want 5", lat); end
    n_tests++;
    if ({sig[0], pass[0]} !== {16'h0000, 1'b1}) begin
      n_fail++; $display("FAIL zero_sig_pass: got sig %h pass %b want 0000/1", sig[0], pass[0]);
    end
  endtask

  task automatic test_data_injection();
    int lat, bc;
    do_reset();
    stim_q = '{6'h01, 6'h01};
    do_run(1, 16'h0003, 0, lat, bc);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL inject_latency: got %0d want 3", lat); end
    if (sig_hist.size() >= 3) begin
      n_tests++;
      if (sig_hist[1] !== 16'h0001) begin
        n_fail++; $display("FAIL inject_step1: got %h want 0001", sig_hist[1]);
      end
      n_tests++;
      if (sig_hist[2] !== 16'h0003) begin
        n_fail++; $display("FAIL inject_step2: got %h want 0003", sig_hist[2]);
      end
    end
    n_tests++;
    if (pass[1] !== 1'b1) begin n_fail++; $display("FAIL inject_pass: got %b want 1", pass[1]); end
    do_run(1, 16'h0004, 0, lat, bc);
    n_tests++;
    if ({done[1], pass[1], sig[1]} !== {2'b10, 16'h0003}) begin
      n_fail++; $display("FAIL inject_mismatch: got d%b p%b sig %h want d1 p0 0003", done[1], pass[1], sig[1]);
    end
  endtask

  task automatic test_feedback();
    int lat, bc;
    do_reset();
    stim_q = '{6'h00};
    do_run(2, 16'h1021, 0, lat, bc);
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL feedback_latency: got %0d want 2", lat); end
    n_tests++;
    if ({sig[2], pass[2]} !== {16'h1021, 1'b1}) begin
      n_fail++; $display("FAIL feedback_sig: got %h pass %b want 1021/1", sig[2], pass[2]);
    end
  endtask

  task automatic test_warmup();
    int lat, bc;
    do_reset();
    fixed_noise = 1'b1;
    stim_q = '{6'h02};
    do_run(3, 16'h0002, 0, lat, bc);
    fixed_noise = 1'b0;
    n_tests++;
    if (lat !== 5) begin n_fail++; $display("FAIL warmup_latency: got %0d want 5", lat); end
    n_tests++;
    if (bc !== 4) begin n_fail++; $display("FAIL warmup_busy_cycles: got %0d want 4", bc); end
    n_tests++;
    if ({sig[3], pass[3]} !== {16'h0002, 1'b1}) begin
      n_fail++; $display("FAIL warmup_sig: got %h pass %b want 0002/1", sig[3], pass[3]);
    end
  endtask

  task automatic test_random_short();
    int lat, bc;
    logic [15:0] m, e;
    do_reset();
    for (int run = 0; run < 8; run++) begin
      stim_q.delete();
      for (int i = 0; i < 4; i++) stim_q.push_back(6'($urandom));
      m = model(16'h0000);
      e = (run % 2 == 0) ? m : (m ^ (16'h0001 << $urandom_range(15, 0)));
      do_run(0, e, 0, lat, bc);
      n_tests++;
      if (lat !== 5 || sig[0] !== m || pass[0] !== (e == m)) begin
        n_fail++;
        $display("FAIL rand_short[%0d]: got lat %0d sig %h pass %b want lat 5 sig %h pass %b",
                 run, lat, sig[0], pass[0], m, (e == m));
      end
    end
  endtask

  task automatic test_s444_runs();
    int lat, bc;
    logic [15:0] m, e;
    do_reset();
    for (int run = 0; run < 3; run++) begin
      stim_q.delete();
      for (int i = 0; i < 1024; i++) stim_q.push_back(6'($urandom));
      m = model(16'h0000);
      e = (run == 1) ? (m ^ 16'h8000) : m;
      // run 2 pulses start mid-compaction; it must not restart or recapture expected
      do_run(4, e, (run == 2) ? 300 : 0, lat, bc);
      n_tests++;
      if (lat !== 1033 || bc !== 1032) begin
        n_fail++; $display("FAIL s444_timing[%0d]: got lat %0d busy %0d want 1033/1032", run, lat, bc);
      end
      n_tests++;
      if (sig[4] !== m || pass[4] !== (e == m)) begin
        n_fail++; $display("FAIL s444_sig[%0d]: got %h pass %b want %h pass %b", run, sig[4], pass[4], m, (e == m));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  r_at [13];
    logic [11:0] d_seen = '0;
    logic [15:0] s5 = '0, s6 = '1, s10 = '0, m1, m2;
    do_reset();
    for (int i = 0; i < 13; i++) r_at[i] = 6'($urandom) | 6'h01;
    start = 1'b1; expected = 16'h0000;
    for (int ed = 1; ed <= 11; ed++) begin
      resp = r_at[ed];
      @(posedge clk); #1;
      d_seen[ed] = done[0];
      if (ed == 5)  s5  = sig[0];
      if (ed == 6)  s6  = sig[0];
      if (ed == 10) s10 = sig[0];
    end
    start = 1'b0;
    stim_q = '{r_at[2], r_at[3], r_at[4], r_at[5]};
    m1 = model(16'h0000);
    stim_q = '{r_at[7], r_at[8], r_at[9], r_at[10]};
    m2 = model(16'h0000);
    n_tests++;
    if (d_seen !== 12'h420) begin
      n_fail++; $display("FAIL b2b_done_pattern: got %b want %b", d_seen, 12'h420);
    end
    n_tests++;
    if (s6 !== 16'h0000) begin n_fail++; $display("FAIL b2b_reload_seed: got %h want 0000", s6); end
    n_tests++;
    if (s5 !== m1 || s10 !== m2) begin
      n_fail++; $display("FAIL b2b_sigs: got %h/%h want %h/%h", s5, s10, m1, m2);
    end
  endtask

  initial begin
    test_reset();
    test_zero_response();
    test_data_injection();
    test_feedback();
    test_warmup();
    test_random_short();
    test_s444_runs();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
